seg7_scan_mux: RTL

//  Downstream consumer of the per-digit BCD latches: captures NUM_DIGITS BCD nibbles

---
 rtl/seg7_scan_mux_pkg.sv | 28 ++
 rtl/seg7_scan_mux_bcd_to_seg7.sv | 26 ++
 rtl/seg7_scan_mux.sv | 129 ++++++++++++
 3 files changed

// File: rtl/seg7_scan_mux_pkg.sv
// Shared segment-pattern constants and bit-order definitions for the 7-segment scan mux.
// Segment vectors are {g,f,e,d,c,b,a}, active-high (common cathode).
package seg7_scan_mux_pkg;

  localparam int SEG_W = 7;

  localparam int SEG_BIT_A = 0;
  localparam int SEG_BIT_B = 1;
  localparam int SEG_BIT_C = 2;
  localparam int SEG_BIT_D = 3;
  localparam int SEG_BIT_E = 4;
  localparam int SEG_BIT_F = 5;
  localparam int SEG_BIT_G = 6;

  localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;
  localparam logic [SEG_W-1:0] SEG_ALL   = 7'h7F;

endpackage

// File: rtl/seg7_scan_mux_bcd_to_seg7.sv
// Combinational BCD to 7-segment decoder; codes 10..15 decode to a dark digit.
module bcd_to_seg7
  import seg7_scan_mux_pkg::*;
(
  input  logic [3:0]       i_bcd,
  output logic [SEG_W-1:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed common-cathode 7-segment driver with shadow capture, lamp test and blanking.
// Optional leading-zero suppression is built when LEADING_ZERO_BLANK_EN is defined.
module seg7_scan_mux
  import seg7_scan_mux_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    load,
  input  logic                    lamp_test_n,
  input  logic                    blank_n,
  output logic [SEG_W-1:0]        seg,
  output logic [NUM_DIGITS-1:0]   dig_n,
  output logic                    frame_done
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [PW-1:0]             r_presc;
  logic [IW-1:0]             r_idx;
  logic [4*NUM_DIGITS-1:0]   r_shadow;
  logic                      w_tick;
  logic                      w_idx_last;
  logic [3:0]                w_cur_bcd;
  logic [SEG_W-1:0]          w_dec_seg;
  logic                      w_cur_lz;
  logic [NUM_DIGITS-1:0]     w_dig_n_scan;

  assign w_tick     = (r_presc == PW'(CLK_DIV - 1));
  assign w_idx_last = (r_idx == IW'(NUM_DIGITS - 1));

  // Refresh prescaler: one tick per digit slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx      <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= w_tick && w_idx_last;
      if (w_tick) begin
        r_idx <= w_idx_last ? '0 : r_idx + IW'(1);
      end
    end
  end

  // load is a level qualifier sampled every edge (no handshake): while high the
  // shadow follows bcd_in, when low it holds the last captured digits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
    end else if (load) begin
      r_shadow <= bcd_in;
    end
  end

  always_comb begin
    w_cur_bcd = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IW'(i)) begin
        w_cur_bcd = r_shadow[i*4 +: 4];
      end
    end
  end

  bcd_to_seg7 u_dec (
    .i_bcd (w_cur_bcd),
    .o_seg (w_dec_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] w_lead_zero;
  logic                  w_zero_run;

  // A digit is suppressed while every digit above it (and itself) is zero;
  // digit 0 always shows so a zero value still displays "0".
  always_comb begin
    w_lead_zero = '0;
    w_zero_run  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      w_zero_run     = w_zero_run && (r_shadow[i*4 +: 4] == 4'd0);
      w_lead_zero[i] = w_zero_run;
    end
  end

  always_comb begin
    w_cur_lz = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IW'(i)) begin
        w_cur_lz = w_lead_zero[i];
      end
    end
  end
`else
  assign w_cur_lz = 1'b0;
`endif

  assign w_dig_n_scan = ~(NUM_DIGITS'(1) << r_idx);

  // Outputs are registered from the current index, so a digit switch shows one edge after the tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg   <= SEG_BLANK;
      dig_n <= '1;
    end else if (!lamp_test_n) begin
      seg   <= SEG_ALL;
      dig_n <= w_dig_n_scan;
    end else if (!blank_n) begin
      seg   <= SEG_BLANK;
      dig_n <= '1;
    end else begin
      seg   <= w_cur_lz ? SEG_BLANK : w_dec_seg;
      dig_n <= w_dig_n_scan;
    end
  end

endmodule
